// File: rtl/ahb_rr_burst_arbiter.sv
// ahb_rr_burst_arbiter
// Per-slave round-robin arbiter with burst-aware grant retention.
// The owner keeps the slave until its burst completes; completion is counted
// on accepted beats (hready high). Drives hmaster (mux select), one-hot hgrant
// and hsel.
module ahb_rr_burst_arbiter #(
    parameter int NUM_MASTER = 4,
    parameter int MASTER_BIT = $clog2(NUM_MASTER)
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [NUM_MASTER-1:0]     hreq,
    input  logic [2*NUM_MASTER-1:0]   htrans_m,
    input  logic [3*NUM_MASTER-1:0]   hburst_m,
    input  logic                      hready,
    output logic [NUM_MASTER-1:0]     hgrant,
    output logic [MASTER_BIT-1:0]     hmaster,
    output logic                      hsel,
    output logic                      hlast
);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [NUM_MASTER-1:0]   hgrant_reg, hgrant_next;
    logic [MASTER_BIT-1:0]   hmaster_reg, hmaster_next;
    logic [MASTER_BIT-1:0]   last_owner_reg, last_owner_next;
    logic [4:0]              count_reg, count_next;
    logic [4:0]              limit_reg, limit_next;

    logic [1:0]              trans_arr [NUM_MASTER];
    logic [2:0]              burst_arr [NUM_MASTER];
    logic [1:0]              owner_trans;
    logic [2:0]              owner_burst;
    logic                    owner_req;

    logic [MASTER_BIT-1:0]   scan_base;
    logic [MASTER_BIT:0]     cand;
    logic [MASTER_BIT-1:0]   winner;
    logic                    found;
    logic                    rel_cond;
    logic [4:0]              new_limit;

    // Split the flat per-master buses so the owner's fields can be indexed directly.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTER; gi++) begin : g_split
            assign trans_arr[gi] = htrans_m[2*gi +: 2];
            assign burst_arr[gi] = hburst_m[3*gi +: 3];
        end
    endgenerate

    assign owner_trans = trans_arr[hmaster_reg];
    assign owner_burst = burst_arr[hmaster_reg];
    assign owner_req   = hreq[hmaster_reg];

    // Beat limit from hburst; 0 stands for an unbounded INCR burst.
    always_comb begin
        new_limit = 5'd1;
        case (owner_burst)
            3'd0:       new_limit = 5'd1;
            3'd1:       new_limit = 5'd0;
            3'd2, 3'd3: new_limit = 5'd4;
            3'd4, 3'd5: new_limit = 5'd8;
            default:    new_limit = 5'd16;
        endcase
    end

    // Round-robin winner: scan from base+1 upward, base itself last.
    always_comb begin
        scan_base = (state_reg == ST_IDLE) ? last_owner_reg : hmaster_reg;
        winner    = scan_base;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_MASTER; k++) begin
            cand = {1'b0, scan_base} + (MASTER_BIT+1)'(k);
            if (cand >= (MASTER_BIT+1)'(NUM_MASTER)) begin
                cand = cand - (MASTER_BIT+1)'(NUM_MASTER);
            end
            if (!found && hreq[cand[MASTER_BIT-1:0]]) begin
                winner = cand[MASTER_BIT-1:0];
                found  = 1'b1;
            end
        end
    end

    // Next-state logic: arbitration, beat counting and release handling.
    always_comb begin
        state_next      = state_reg;
        hgrant_next     = hgrant_reg;
        hmaster_next    = hmaster_reg;
        last_owner_next = last_owner_reg;
        count_next      = count_reg;
        limit_next      = limit_reg;
        rel_cond        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (|hreq) begin
                    hgrant_next  = NUM_MASTER'(1) << winner;
                    hmaster_next = winner;
                    state_next   = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (owner_trans == TR_NONSEQ) begin
                    rel_cond = (new_limit == 5'd1);
                    if (hready) begin
                        limit_next = new_limit;
                        count_next = 5'd1;
                        state_next = ST_BURST;
                    end
                end else if (owner_trans == TR_IDLE && !owner_req) begin
                    rel_cond = 1'b1;
                end
            end
            ST_BURST: begin
                case (owner_trans)
                    TR_IDLE: rel_cond = 1'b1;
                    TR_NONSEQ: rel_cond = (limit_reg == 5'd0);
                    TR_BUSY: rel_cond = (limit_reg == 5'd0) && !owner_req;
                    TR_SEQ: begin
                        if (limit_reg == 5'd0) begin
                            rel_cond = !owner_req;
                            if (hready && count_reg != 5'd31) begin
                                count_next = count_reg + 5'd1;
                            end
                        end else if (count_reg + 5'd1 == limit_reg) begin
                            rel_cond = 1'b1;
                        end else if (hready) begin
                            count_next = count_reg + 5'd1;
                        end
                    end
                    default: rel_cond = 1'b0;
                endcase
            end
            default: state_next = ST_IDLE;
        endcase

        // Release hands over to the next requester on the same edge.
        if (hready && rel_cond) begin
            last_owner_next = hmaster_reg;
            count_next      = 5'd0;
            limit_next      = 5'd0;
            if (|hreq) begin
                hgrant_next  = NUM_MASTER'(1) << winner;
                hmaster_next = winner;
                state_next   = ST_ARMED;
            end else begin
                hgrant_next  = '0;
                state_next   = ST_IDLE;
            end
        end
    end

    // State registers; reset leaves master 0 with first priority.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_reg      <= ST_IDLE;
            hgrant_reg     <= '0;
            hmaster_reg    <= '0;
            last_owner_reg <= MASTER_BIT'(NUM_MASTER - 1);
            count_reg      <= 5'd0;
            limit_reg      <= 5'd0;
        end else begin
            state_reg      <= state_next;
            hgrant_reg     <= hgrant_next;
            hmaster_reg    <= hmaster_next;
            last_owner_reg <= last_owner_next;
            count_reg      <= count_next;
            limit_reg      <= limit_next;
        end
    end

    assign hgrant  = hgrant_reg;
    assign hmaster = hmaster_reg;
    assign hsel    = |hgrant_reg;
    assign hlast   = hready & rel_cond;

endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
// Directed testbench for ahb_rr_burst_arbiter (NUM_MASTER = 4).
module tb_ahb_rr_burst_arbiter;

    logic        hclk = 1'b0;
    logic        hreset_n;
    logic [3:0]  hreq;
    logic [7:0]  htrans_m;
    logic [11:0] hburst_m;
    logic        hready;
    logic [3:0]  hgrant;
    logic [1:0]  hmaster;
    logic        hsel;
    logic        hlast;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;

    ahb_rr_burst_arbiter #(.NUM_MASTER(4)) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .hreq     (hreq),
        .htrans_m (htrans_m),
        .hburst_m (hburst_m),
        .hready   (hready),
        .hgrant   (hgrant),
        .hmaster  (hmaster),
        .hsel     (hsel),
        .hlast    (hlast)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_m(input int m, input logic [1:0] t, input logic [2:0] b);
        htrans_m[2*m +: 2] = t;
        hburst_m[3*m +: 3] = b;
    endtask

    initial begin
        hreset_n = 1'b0;
        hreq     = 4'b0000;
        htrans_m = '0;
        hburst_m = '0;
        hready   = 1'b1;
        step();
        step();
        chk("rst_hgrant", hgrant, 4'b0000);
        chk("rst_hmaster", hmaster, 2'd0);
        chk("rst_hsel", hsel, 1'b0);
        hreset_n = 1'b1;

        // Two requesters: master 0 wins first, does a SINGLE, master 2 follows.
        hreq = 4'b0101;
        step();
        chk("t1_grant0", hgrant, 4'b0001);
        chk("t1_master0", hmaster, 2'd0);
        chk("t1_hsel", hsel, 1'b1);
        set_m(0, NONSEQ, SINGLE);
        #1;
        chk("t1_hlast", hlast, 1'b1);
        step();
        chk("t1_grant2", hgrant, 4'b0100);
        chk("t1_master2", hmaster, 2'd2);
        set_m(0, IDLE, SINGLE);

        // Master 2 SINGLE; masters 1 and 2 requesting -> master 1 next.
        hreq = 4'b0110;
        set_m(2, NONSEQ, SINGLE);
        step();
        chk("t2_grant1", hgrant, 4'b0010);
        set_m(2, IDLE, SINGLE);
        hreq = 4'b1010;

        // Master 1 INCR4 with a two-cycle wait state, master 3 pending.
        set_m(1, NONSEQ, INCR4);
        #1;
        chk("t2_hlast_nonseq", hlast, 1'b0);
        step();
        set_m(1, SEQ, INCR4);
        step();
        hready = 1'b0;
        #1;
        chk("t2_hlast_wait", hlast, 1'b0);
        step();
        chk("t2_hold_wait", hgrant, 4'b0010);
        step();
        hready = 1'b1;
        #1;
        chk("t2_hlast_beat3", hlast, 1'b0);
        step();
        chk("t2_hold_beat3", hgrant, 4'b0010);
        chk("t2_hlast_beat4", hlast, 1'b1);
        step();
        chk("t2_grant3", hgrant, 4'b1000);
        chk("t2_master3", hmaster, 2'd3);
        set_m(1, IDLE, SINGLE);

        // All masters request continuously with SINGLEs: 3 -> 0,1,2,3,0.
        hreq = 4'b1111;
        for (int m = 0; m < 4; m++) set_m(m, NONSEQ, SINGLE);
        step();
        chk("t3_rr0", hgrant, 4'b0001);
        step();
        chk("t3_rr1", hgrant, 4'b0010);
        step();
        chk("t3_rr2", hgrant, 4'b0100);
        step();
        chk("t3_rr3", hgrant, 4'b1000);
        step();
        chk("t3_rr0b", hgrant, 4'b0001);
        chk("t3_master0", hmaster, 2'd0);

        // Master 0 drops its request while IDLE: released, master 2 granted.
        for (int m = 0; m < 4; m++) set_m(m, IDLE, SINGLE);
        hreq = 4'b0100;
        #1;
        chk("t3_drop_hlast", hlast, 1'b1);
        step();
        chk("t4_grant2", hgrant, 4'b0100);

        // Master 2 INCR16 with two BUSY beats; master 0 pending.
        hreq = 4'b0101;
        set_m(2, NONSEQ, INCR16);
        step();
        for (int i = 1; i <= 14; i++) begin
            set_m(2, SEQ, INCR16);
            step();
            if (i == 5 || i == 10) begin
                set_m(2, BUSY, INCR16);
                #1;
                chk("t4_busy_hlast", hlast, 1'b0);
                step();
            end
        end
        set_m(2, SEQ, INCR16);
        #1;
        chk("t4_hold_beat16", hgrant, 4'b0100);
        chk("t4_hlast_beat16", hlast, 1'b1);
        step();
        chk("t4_grant0", hgrant, 4'b0001);
        set_m(2, IDLE, SINGLE);

        // Master 0 INCR8 terminated after 3 beats; master 1 pending.
        hreq = 4'b0011;
        set_m(0, NONSEQ, INCR8);
        step();
        set_m(0, SEQ, INCR8);
        step();
        step();
        set_m(0, IDLE, INCR8);
        #1;
        chk("t5_early_hlast", hlast, 1'b1);
        step();
        chk("t5_grant1", hgrant, 4'b0010);
        chk("t5_master1", hmaster, 2'd1);

        // Master 1 SINGLE hands to master 3; reset in the middle of its burst.
        hreq = 4'b1000;
        set_m(1, NONSEQ, SINGLE);
        step();
        chk("t6_master3", hmaster, 2'd3);
        set_m(1, IDLE, SINGLE);
        set_m(3, NONSEQ, INCR8);
        step();
        set_m(3, SEQ, INCR8);
        step();
        #2;
        hreset_n = 1'b0;
        #1;
        chk("t6_rst_hgrant", hgrant, 4'b0000);
        chk("t6_rst_hsel", hsel, 1'b0);
        step();
        hreset_n = 1'b1;
        set_m(3, IDLE, SINGLE);
        hreq = 4'b1111;
        step();
        chk("t6_grant0", hgrant, 4'b0001);
        chk("t6_master0", hmaster, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
